// File: rtl/bf_branch_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bf_branch_unit_pkg                                            |
// | Purpose  : Shared types and codes for the bfX loop controller: state     |
// |            encodings, error codes and default geometry.                  |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package bf_branch_unit_pkg;

   localparam int C_PC_W_DEF   = 16;
   localparam int C_DEPTH_DEF  = 16;
   localparam int C_NEST_W_DEF = 8;

   // Controller states; encodings are visible to debug tooling.
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_SKIP  = 2'd1,
      ST_ERROR = 2'd2
   } bf_state_e;

   // Values driven on err_code.
   typedef enum logic [1:0] {
      ERR_NONE = 2'd0,
      ERR_OVF  = 2'd1,
      ERR_UNF  = 2'd2,
      ERR_ILL  = 2'd3
   } bf_err_e;

endpackage : bf_branch_unit_pkg
`default_nettype wire

// File: rtl/bf_branch_unit_loop_stack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bf_loop_stack                                                 |
// | Purpose  : LIFO of open-bracket PCs (PC_W x DEPTH) for the loop          |
// |            controller.                                                   |
// | Ports    : clk, rst_n      clock / async active-low reset                |
// |            push_i, pop_i   stack operations (never both in one cycle)    |
// |            din_i           value pushed                                  |
// |            top_o           most recently pushed value                    |
// |            full_o, empty_o occupancy flags                               |
// |            depth_o         number of valid entries                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module bf_loop_stack #(
   parameter int PC_W  = 16,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [PC_W-1:0]          din_i,
   output logic [PC_W-1:0]          top_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   depth_o
);

   localparam int C_IDX_W = $clog2(DEPTH);
   localparam int C_CNT_W = C_IDX_W + 1;

   logic [PC_W-1:0]    mem_q [DEPTH];
   logic [C_CNT_W-1:0] count_q;
   logic [C_CNT_W-1:0] count_d;
   logic [C_CNT_W-1:0] w_top_ptr;
   logic               w_do_push;
   logic               w_do_pop;

   assign full_o    = (count_q == C_CNT_W'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign depth_o   = count_q;
   assign w_do_push = push_i & ~full_o;
   assign w_do_pop  = pop_i & ~empty_o;

   // Top entry sits one below the fill pointer; value is don't-care when empty.
   assign w_top_ptr = count_q - C_CNT_W'(1);
   assign top_o     = mem_q[w_top_ptr[C_IDX_W-1:0]];

   always_comb begin
      count_d = count_q;
      if (w_do_push) begin
         count_d = count_q + C_CNT_W'(1);
      end else if (w_do_pop) begin
         count_d = count_q - C_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Storage needs no reset: entries are only read below the fill pointer.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         mem_q[count_q[C_IDX_W-1:0]] <= din_i;
      end
   end

endmodule : bf_loop_stack
`default_nettype wire

// File: rtl/bf_branch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bf_branch_unit                                                |
// | Purpose  : Execute-stage loop controller. Tracks open-bracket PCs,       |
// |            redirects fetch on taken ']', forward-skips loops entered     |
// |            with a zero cell, and halts on nesting errors.                |
// | Ports    : clk, rst_n          clock / async active-low reset            |
// |            ix_valid/open/close decoded instruction strobes               |
// |            ix_pc               address of decoded instruction            |
// |            cell_zero           current data cell is zero                 |
// |            pc_load, pc_target  registered redirect to fetch              |
// |            skipping, halt      SKIP / ERROR state indicators             |
// |            err_code            0 none, 1 overflow, 2 underflow, 3 illegal|
// |            depth               return-stack occupancy                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module bf_branch_unit
   import bf_branch_unit_pkg::*;
#(
   parameter int PC_W   = C_PC_W_DEF,
   parameter int DEPTH  = C_DEPTH_DEF,
   parameter int NEST_W = C_NEST_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ix_valid,
   input  logic                     ix_open,
   input  logic                     ix_close,
   input  logic [PC_W-1:0]          ix_pc,
   input  logic                     cell_zero,
   output logic                     pc_load,
   output logic [PC_W-1:0]          pc_target,
   output logic                     skipping,
   output logic                     halt,
   output logic [1:0]               err_code,
   output logic [$clog2(DEPTH):0]   depth
);

   bf_state_e         state_q, state_d;
   bf_err_e           err_q, err_d;
   logic [NEST_W-1:0] nest_q, nest_d;
   logic              pc_load_q, pc_load_d;
   logic [PC_W-1:0]   pc_target_q, pc_target_d;

   logic              w_push;
   logic              w_pop;
   logic [PC_W-1:0]   w_top;
   logic              w_full;
   logic              w_empty;
   logic              w_accept;

   // The slot right after a redirect belongs to the wrong-path fetch.
   assign w_accept = ix_valid & ~pc_load_q;

   bf_loop_stack #(
      .PC_W  (PC_W),
      .DEPTH (DEPTH)
   ) u_stack (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (w_push),
      .pop_i   (w_pop),
      .din_i   (ix_pc),
      .top_o   (w_top),
      .full_o  (w_full),
      .empty_o (w_empty),
      .depth_o (depth)
   );

   always_comb begin
      state_d     = state_q;
      err_d       = err_q;
      nest_d      = nest_q;
      pc_load_d   = 1'b0;
      pc_target_d = pc_target_q;
      w_push      = 1'b0;
      w_pop       = 1'b0;

      if (w_accept && (state_q != ST_ERROR)) begin
         if (ix_open && ix_close) begin
            state_d = ST_ERROR;
            err_d   = ERR_ILL;
         end else begin
            case (state_q)
               ST_RUN: begin
                  if (ix_open) begin
                     if (cell_zero) begin
                        nest_d  = NEST_W'(1);
                        state_d = ST_SKIP;
                     end else if (w_full) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_OVF;
                     end else begin
                        w_push = 1'b1;
                     end
                  end else if (ix_close) begin
                     if (w_empty) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_UNF;
                     end else if (cell_zero) begin
                        w_pop = 1'b1;
                     end else begin
                        // Loop back to the instruction after the matching '['.
                        pc_load_d   = 1'b1;
                        pc_target_d = w_top + PC_W'(1);
                     end
                  end
               end
               ST_SKIP: begin
                  if (ix_open) begin
                     if (&nest_q) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_OVF;
                     end else begin
                        nest_d = nest_q + NEST_W'(1);
                     end
                  end else if (ix_close) begin
                     nest_d = nest_q - NEST_W'(1);
                     if (nest_q == NEST_W'(1)) begin
                        state_d = ST_RUN;
                     end
                  end
               end
               default: begin
                  state_d = state_q;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         err_q       <= ERR_NONE;
         nest_q      <= '0;
         pc_load_q   <= 1'b0;
         pc_target_q <= '0;
      end else begin
         state_q     <= state_d;
         err_q       <= err_d;
         nest_q      <= nest_d;
         pc_load_q   <= pc_load_d;
         pc_target_q <= pc_target_d;
      end
   end

   assign pc_load   = pc_load_q;
   assign pc_target = pc_target_q;
   assign skipping  = (state_q == ST_SKIP);
   assign halt      = (state_q == ST_ERROR);
   assign err_code  = err_q;

endmodule : bf_branch_unit
`default_nettype wire

// File: tb/tb_bf_branch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bf_branch_unit                                             |
// | Purpose  : Directed self-checking bench for bf_branch_unit with a        |
// |            queue of expected post-edge output snapshots.                 |
// | Ports    : none                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_bf_branch_unit;

   localparam int PC_W   = 16;
   localparam int DEPTH  = 16;
   localparam int NEST_W = 8;

   logic        clk;
   logic        rst_n;
   logic        ix_valid;
   logic        ix_open;
   logic        ix_close;
   logic [15:0] ix_pc;
   logic        cell_zero;
   logic        pc_load;
   logic [15:0] pc_target;
   logic        skipping;
   logic        halt;
   logic [1:0]  err_code;
   logic [4:0]  depth;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       tag;
      logic        pl;
      logic [15:0] tgt;
      logic        sk;
      logic        ht;
      logic [1:0]  ec;
      logic [4:0]  dp;
   } exp_t;

   exp_t sb[$];

   bf_branch_unit #(
      .PC_W   (PC_W),
      .DEPTH  (DEPTH),
      .NEST_W (NEST_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ix_valid  (ix_valid),
      .ix_open   (ix_open),
      .ix_close  (ix_close),
      .ix_pc     (ix_pc),
      .cell_zero (cell_zero),
      .pc_load   (pc_load),
      .pc_target (pc_target),
      .skipping  (skipping),
      .halt      (halt),
      .err_code  (err_code),
      .depth     (depth)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic pl, input logic [15:0] tgt,
                             input logic sk, input logic ht, input logic [1:0] ec,
                             input logic [4:0] dp);
      exp_t e;
      e.tag = tag; e.pl = pl; e.tgt = tgt; e.sk = sk; e.ht = ht; e.ec = ec; e.dp = dp;
      sb.push_back(e);
   endtask

   task automatic compare_out();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard observed=empty expected=entry");
      end else begin
         e = sb.pop_front();
         chk({e.tag, "/pc_load"}, 32'(pc_load), 32'(e.pl));
         if (e.pl) chk({e.tag, "/pc_target"}, 32'(pc_target), 32'(e.tgt));
         chk({e.tag, "/skipping"}, 32'(skipping), 32'(e.sk));
         chk({e.tag, "/halt"}, 32'(halt), 32'(e.ht));
         chk({e.tag, "/err_code"}, 32'(err_code), 32'(e.ec));
         chk({e.tag, "/depth"}, 32'(depth), 32'(e.dp));
      end
   endtask

   // Drive one instruction slot, record the expected state after the edge.
   task automatic step(input logic v, input logic o, input logic c, input logic [15:0] pc,
                       input logic cz, input string tag, input logic pl,
                       input logic [15:0] tgt, input logic sk, input logic ht,
                       input logic [1:0] ec, input logic [4:0] dp);
      ix_valid  = v;
      ix_open   = o;
      ix_close  = c;
      ix_pc     = pc;
      cell_zero = cz;
      expect_out(tag, pl, tgt, sk, ht, ec, dp);
      @(posedge clk);
      #1;
      compare_out();
   endtask

   // Asynchronous reset applied between edges; outputs must clear at once.
   task automatic do_reset(input string tag);
      ix_valid  = 1'b0;
      ix_open   = 1'b0;
      ix_close  = 1'b0;
      ix_pc     = '0;
      cell_zero = 1'b0;
      rst_n     = 1'b0;
      expect_out(tag, 1'b0, 16'h0, 1'b0, 1'b0, 2'd0, 5'd0);
      #1;
      compare_out();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      ix_valid  = 1'b0;
      ix_open   = 1'b0;
      ix_close  = 1'b0;
      ix_pc     = '0;
      cell_zero = 1'b0;
      @(negedge clk);
      do_reset("por");

      // Basic loop: push, taken close, squashed slot, fall-through close.
      step(1, 1, 0, 16'h0004, 0, "open4",       0, 16'h0000, 0, 0, 2'd0, 5'd1);
      step(1, 0, 1, 16'h0009, 0, "close_redir", 1, 16'h0005, 0, 0, 2'd0, 5'd1);
      step(1, 0, 1, 16'h0009, 0, "squash",      0, 16'h0000, 0, 0, 2'd0, 5'd1);
      step(1, 0, 1, 16'h0009, 1, "close_pop",   0, 16'h0000, 0, 0, 2'd0, 5'd0);
      step(0, 0, 1, 16'h000A, 0, "invalid",     0, 16'h0000, 0, 0, 2'd0, 5'd0);
      step(1, 0, 0, 16'h000B, 0, "nonbracket",  0, 16'h0000, 0, 0, 2'd0, 5'd0);

      // Forward skip over a nested loop.
      step(1, 1, 0, 16'h0010, 1, "skip_open",   0, 16'h0000, 1, 0, 2'd0, 5'd0);
      step(1, 1, 0, 16'h0011, 0, "skip_nest",   0, 16'h0000, 1, 0, 2'd0, 5'd0);
      step(1, 0, 1, 16'h0012, 0, "skip_close1", 0, 16'h0000, 1, 0, 2'd0, 5'd0);
      step(1, 0, 1, 16'h0013, 0, "skip_close0", 0, 16'h0000, 0, 0, 2'd0, 5'd0);

      // Target arithmetic wraps modulo 2^16.
      step(1, 1, 0, 16'hFFFF, 0, "wrap_open",   0, 16'h0000, 0, 0, 2'd0, 5'd1);
      step(1, 0, 1, 16'h0002, 0, "wrap_redir",  1, 16'h0000, 0, 0, 2'd0, 5'd1);
      step(0, 0, 0, 16'h0000, 0, "wrap_idle",   0, 16'h0000, 0, 0, 2'd0, 5'd1);
      step(1, 0, 1, 16'h0002, 1, "wrap_pop",    0, 16'h0000, 0, 0, 2'd0, 5'd0);

      // Reset in the middle of a skip with nest=3.
      step(1, 1, 0, 16'h0020, 1, "rs_open1",    0, 16'h0000, 1, 0, 2'd0, 5'd0);
      step(1, 1, 0, 16'h0021, 1, "rs_open2",    0, 16'h0000, 1, 0, 2'd0, 5'd0);
      step(1, 1, 0, 16'h0022, 1, "rs_open3",    0, 16'h0000, 1, 0, 2'd0, 5'd0);
      do_reset("rst_skip");
      step(0, 0, 0, 16'h0000, 0, "post_rst",    0, 16'h0000, 0, 0, 2'd0, 5'd0);

      // Reset while a redirect pulse is being presented.
      step(1, 1, 0, 16'h0030, 0, "rr_open",     0, 16'h0000, 0, 0, 2'd0, 5'd1);
      step(1, 0, 1, 16'h0031, 0, "rr_redir",    1, 16'h0031, 0, 0, 2'd0, 5'd1);
      do_reset("rst_redir");

      // Underflow, then inputs ignored while halted.
      step(1, 0, 1, 16'h0040, 0, "underflow",   0, 16'h0000, 0, 1, 2'd2, 5'd0);
      step(1, 1, 0, 16'h0041, 0, "unf_sticky",  0, 16'h0000, 0, 1, 2'd2, 5'd0);
      do_reset("rst_unf");

      // Simultaneous open and close.
      step(1, 1, 1, 16'h0050, 0, "illegal",     0, 16'h0000, 0, 1, 2'd3, 5'd0);
      do_reset("rst_ill");

      // Stack overflow on the seventeenth push.
      for (int i = 0; i < DEPTH; i++) begin
         step(1, 1, 0, 16'(i), 0, "ovf_fill",   0, 16'h0000, 0, 0, 2'd0, 5'(i + 1));
      end
      step(1, 1, 0, 16'h0100, 0, "overflow",    0, 16'h0000, 0, 1, 2'd1, 5'd16);
      step(1, 0, 1, 16'h0101, 1, "ovf_sticky",  0, 16'h0000, 0, 1, 2'd1, 5'd16);
      do_reset("rst_ovf");

      // Skip nesting counter overflow at all-ones.
      step(1, 1, 0, 16'h0200, 1, "nest_enter",  0, 16'h0000, 1, 0, 2'd0, 5'd0);
      for (int i = 0; i < 254; i++) begin
         step(1, 1, 0, 16'h0201, 0, "nest_fill", 0, 16'h0000, 1, 0, 2'd0, 5'd0);
      end
      step(1, 1, 0, 16'h0300, 0, "nest_ovf",    0, 16'h0000, 0, 1, 2'd1, 5'd0);
      do_reset("rst_nest");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_bf_branch_unit
`default_nettype wire
